// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Brief    : Shared types and constants for the Mono_Ciclo fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_RANGE    = 2'd2
  } fault_cause_t;

  localparam int INST_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/pc_check.sv
// ============================================================================
// Module   : pc_check
// Brief    : Combinational fetch-address legality check (alignment, range).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_check
  import core_pkg::*;
#(
  parameter int ADR_W     = 64,
  parameter int MEM_DEPTH = 80
) (
  input  logic [ADR_W-1:0] pc,
  output logic             ok,
  output fault_cause_t     cause
);

  logic [ADR_W-1:0] w_word;
  logic             w_misalign;
  logic             w_range;

  assign w_word     = pc >> 2;
  assign w_misalign = (pc[1:0] != 2'b00);
  assign w_range    = (w_word >= ADR_W'(MEM_DEPTH));

  // Misalignment is reported ahead of range when both apply.
  always_comb begin
    cause = FC_NONE;
    if (w_misalign)   cause = FC_MISALIGN;
    else if (w_range) cause = FC_RANGE;
  end

  assign ok = (cause == FC_NONE);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register and fetch control with valid/ready output to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import core_pkg::*;
#(
  parameter int             ADR_W     = 64,
  parameter int             INST_W    = 32,
  parameter int             MEM_DEPTH = 80,
  parameter logic [ADR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADR_W-1:0]  read_adr,
  input  logic [INST_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADR_W-1:0]  redirect_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADR_W-1:0]  if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [31:0]       fetch_count
);

  fetch_state_t      r_state;
  logic [ADR_W-1:0]  r_pc;
  logic              r_if_valid;
  logic [ADR_W-1:0]  r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              r_fault;
  fault_cause_t      r_cause;
  logic [31:0]       r_count;

  logic              w_ok;
  fault_cause_t      w_cause;
  logic              w_load;
  logic              w_redirect;
  logic              w_xfer;

  pc_check #(
    .ADR_W     (ADR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc_check (
    .pc    (r_pc),
    .ok    (w_ok),
    .cause (w_cause)
  );

  assign w_redirect = redirect_valid && (r_state != BOOT);
  assign w_load     = !r_if_valid || if_ready;
  // A redirect squashes the pending output, so it is never counted.
  assign w_xfer     = r_if_valid && if_ready && !w_redirect;

  assign read_adr = ((r_state == RUN) && w_ok) ? (r_pc >> 2) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_fault    <= 1'b0;
      r_cause    <= FC_NONE;
      r_count    <= '0;
    end else begin
      if (w_xfer && (r_count != 32'hFFFF_FFFF)) begin
        r_count <= r_count + 32'd1;
      end
      case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            r_pc       <= redirect_target;
            r_if_valid <= 1'b0;
          end else if (!w_ok) begin
            r_state    <= HALT;
            r_fault    <= 1'b1;
            r_cause    <= w_cause;
            r_if_valid <= 1'b0;
          end else if (w_load) begin
            r_if_inst  <= instruction;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + ADR_W'(INST_BYTES);
          end
        end
        HALT: begin
          r_if_valid <= 1'b0;
          if (redirect_valid) begin
            r_state <= RUN;
            r_pc    <= redirect_target;
            r_fault <= 1'b0;
            r_cause <= FC_NONE;
          end
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_inst     = r_if_inst;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed self-checking bench for pc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam int ADR_W     = 64;
  localparam int INST_W    = 32;
  localparam int MEM_DEPTH = 80;

  logic              clk;
  logic              rst;
  logic [ADR_W-1:0]  read_adr;
  logic [INST_W-1:0] instruction;
  logic              redirect_valid;
  logic [ADR_W-1:0]  redirect_target;
  logic              if_valid;
  logic              if_ready;
  logic [ADR_W-1:0]  if_pc;
  logic [INST_W-1:0] if_inst;
  logic              fault;
  logic [1:0]        fault_cause;
  logic [31:0]       fetch_count;

  int n_pass;
  int n_total;

  pc_fetch_unit #(
    .ADR_W     (ADR_W),
    .INST_W    (INST_W),
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  ('0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_adr        (read_adr),
    .instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .fault           (fault),
    .fault_cause     (fault_cause),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] mem_word(input logic [ADR_W-1:0] idx);
    if (idx < ADR_W'(MEM_DEPTH)) return 32'hA000_0000 + idx[31:0];
    return 32'hDEAD_BEEF;
  endfunction

  assign instruction = mem_word(read_adr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; if_ready = 1'b0;
    tick(); tick();
    n_total++;
    if (if_valid !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'd0 ||
        fetch_count !== 32'd0 || read_adr !== 64'd0 || if_pc !== 64'd0 || if_inst !== 32'd0)
      $display("FAIL reset_state: valid=%0b fault=%0b cause=%0d cnt=%0d adr=%0h pc=%0h inst=%0h required all zero",
               if_valid, fault, fault_cause, fetch_count, read_adr, if_pc, if_inst);
    else n_pass++;
    rst = 1'b0; if_ready = 1'b1;
    tick();
    n_total++;
    if (if_valid !== 1'b0 || read_adr !== 64'd0)
      $display("FAIL boot_idle: valid=%0b adr=%0h required valid=0 adr=0", if_valid, read_adr);
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 64'(4*k) || if_inst !== 32'hA000_0000 + 32'(k) ||
          read_adr !== 64'(k+1) || fetch_count !== 32'(k))
        $display("FAIL stream_%0d: valid=%0b pc=%0h inst=%0h adr=%0h cnt=%0d required 1/%0h/%0h/%0h/%0d",
                 k, if_valid, if_pc, if_inst, read_adr, fetch_count,
                 4*k, 32'hA000_0000 + 32'(k), k+1, k);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 64'h8 || if_inst !== 32'hA000_0002 ||
          read_adr !== 64'd3 || fetch_count !== 32'd2)
        $display("FAIL stall_%0d: valid=%0b pc=%0h inst=%0h adr=%0h cnt=%0d required 1/8/a0000002/3/2",
                 k, if_valid, if_pc, if_inst, read_adr, fetch_count);
      else n_pass++;
    end
    if_ready = 1'b1;
    tick();
    n_total++;
    if (if_pc !== 64'hC || if_inst !== 32'hA000_0003 || fetch_count !== 32'd3)
      $display("FAIL stall_release: pc=%0h inst=%0h cnt=%0d required c/a0000003/3",
               if_pc, if_inst, fetch_count);
    else n_pass++;
  endtask

  task automatic test_redirect();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h40;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if (if_valid !== 1'b0 || read_adr !== 64'h10 || fetch_count !== 32'd3)
      $display("FAIL redirect_squash: valid=%0b adr=%0h cnt=%0d required 0/10/3",
               if_valid, read_adr, fetch_count);
    else n_pass++;
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 64'h40 || if_inst !== 32'hA000_0010 || fetch_count !== 32'd3)
      $display("FAIL redirect_target: valid=%0b pc=%0h inst=%0h cnt=%0d required 1/40/a0000010/3",
               if_valid, if_pc, if_inst, fetch_count);
    else n_pass++;
  endtask

  task automatic test_fault_misalign();
    redirect_valid = 1'b1; redirect_target = 64'h42;
    tick();
    // Redirect during the detection cycle of 0x42 must pre-empt the fault.
    redirect_target = 64'h8;
    tick();
    n_total++;
    if (fault !== 1'b0 || read_adr !== 64'd2)
      $display("FAIL redirect_beats_fault: fault=%0b adr=%0h required 0/2", fault, read_adr);
    else n_pass++;
    redirect_target = 64'h42;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_total++;
    if (fault !== 1'b1 || fault_cause !== 2'd1 || if_valid !== 1'b0 || read_adr !== 64'd0)
      $display("FAIL misalign_halt: fault=%0b cause=%0d valid=%0b adr=%0h required 1/1/0/0",
               fault, fault_cause, if_valid, read_adr);
    else n_pass++;
    if_ready = 1'b1;
    tick();
    n_total++;
    if (fault !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd3)
      $display("FAIL halt_sticky: fault=%0b valid=%0b cnt=%0d required 1/0/3", fault, if_valid, fetch_count);
    else n_pass++;
    redirect_valid = 1'b1; redirect_target = 64'h10;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if (fault !== 1'b0 || fault_cause !== 2'd0 || read_adr !== 64'd4)
      $display("FAIL fault_clear: fault=%0b cause=%0d adr=%0h required 0/0/4", fault, fault_cause, read_adr);
    else n_pass++;
    if_ready = 1'b0;
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 64'h10 || if_inst !== 32'hA000_0004)
      $display("FAIL after_clear: valid=%0b pc=%0h inst=%0h required 1/10/a0000004", if_valid, if_pc, if_inst);
    else n_pass++;
  endtask

  task automatic test_range();
    redirect_valid = 1'b1; redirect_target = 64'h13C;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 64'h13C || if_inst !== 32'hA000_004F || fetch_count !== 32'd3)
      $display("FAIL last_word: valid=%0b pc=%0h inst=%0h cnt=%0d required 1/13c/a000004f/3",
               if_valid, if_pc, if_inst, fetch_count);
    else n_pass++;
    tick();
    n_total++;
    if (fault !== 1'b1 || fault_cause !== 2'd2 || if_valid !== 1'b0 || fetch_count !== 32'd4)
      $display("FAIL range_fault: fault=%0b cause=%0d valid=%0b cnt=%0d required 1/2/0/4",
               fault, fault_cause, if_valid, fetch_count);
    else n_pass++;
    tick();
    n_total++;
    if (if_valid !== 1'b0 || read_adr !== 64'd0 || fault_cause !== 2'd2)
      $display("FAIL range_hold: valid=%0b adr=%0h cause=%0d required 0/0/2", if_valid, read_adr, fault_cause);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h20;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 64'h20 || fetch_count !== 32'd4)
      $display("FAIL stall_0x20: valid=%0b pc=%0h cnt=%0d required 1/20/4", if_valid, if_pc, fetch_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (if_valid !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'd0 || if_pc !== 64'd0 || read_adr !== 64'd0)
      $display("FAIL async_reset: valid=%0b fault=%0b cnt=%0d pc=%0h adr=%0h required all zero",
               if_valid, fault, fetch_count, if_pc, read_adr);
    else n_pass++;
    tick();
    rst = 1'b0; if_ready = 1'b1;
    tick(); tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 64'd0 || if_inst !== 32'hA000_0000 || read_adr !== 64'd1)
      $display("FAIL restart_pc: valid=%0b pc=%0h inst=%0h adr=%0h required 1/0/a0000000/1",
               if_valid, if_pc, if_inst, read_adr);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault_misalign();
    test_range();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
